// File: rtl/spatz_boot_ctrl_resp.sv
// rtl/spatz_boot_ctrl_resp.sv - boot control register window with req/rsp handshake
// Holds the boot entry point, issues per-core wake pulses and reports sticky status.
module spatz_boot_ctrl_resp #(
  parameter int unsigned           AddrWidth = 48,
  parameter int unsigned           DataWidth = 64,
  parameter int unsigned           NumCores  = 2,
  parameter logic [AddrWidth-1:0]  BaseAddr  = '0,
  localparam int unsigned          StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [DataWidth-1:0] q_data_i,
  input  logic [StrbWidth-1:0] q_strb_i,
  input  logic [3:0]           q_amo_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  output logic [DataWidth-1:0] p_data_o,
  output logic                 p_error_o,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic [31:0]          entry_point_o,
  output logic [NumCores-1:0]  debug_req_o,
  output logic                 entry_valid_o
);

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e                r_state;
  logic [31:0]           r_entry;
  logic                  r_entry_valid;
  logic                  r_woken;
  logic [NumCores-1:0]   r_debug_req;
  logic                  r_p_valid;
  logic [DataWidth-1:0]  r_p_data;
  logic                  r_p_error;

  logic [AddrWidth-1:0]  w_offset;
  logic                  w_hit;
  logic                  w_err;
  logic                  w_sel_boot;
  logic                  w_sel_wake;
  logic                  w_sel_status;
  logic [DataWidth-1:0]  w_rdata;
  logic [NumCores-1:0]   w_mask;
  logic                  w_unused;

  // Addresses below BaseAddr wrap to a huge offset and therefore miss.
  assign w_offset     = q_addr_i - BaseAddr;
  assign w_hit        = (w_offset < AddrWidth'(24)) && (w_offset[2:0] == 3'b000);
  assign w_err        = !w_hit || (q_amo_i != 4'd0);
  assign w_sel_boot   = w_hit && (w_offset[4:3] == 2'd0);
  assign w_sel_wake   = w_hit && (w_offset[4:3] == 2'd1);
  assign w_sel_status = w_hit && (w_offset[4:3] == 2'd2);
  assign w_mask       = q_data_i[NumCores-1:0];
  assign w_unused     = ^{q_data_i[DataWidth-1:32], q_strb_i[StrbWidth-1:4]};

  always_comb begin
    w_rdata = '0;
    if (!q_write_i && !w_err) begin
      if (w_sel_boot)   w_rdata = DataWidth'(r_entry);
      if (w_sel_status) w_rdata = DataWidth'({r_woken, r_entry_valid});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_entry       <= '0;
      r_entry_valid <= 1'b0;
      r_woken       <= 1'b0;
      r_debug_req   <= '0;
      r_p_valid     <= 1'b0;
      r_p_data      <= '0;
      r_p_error     <= 1'b0;
    end else begin
      r_debug_req <= '0;
      case (r_state)
        S_IDLE: begin
          if (q_valid_i) begin
            r_state   <= S_RESP;
            r_p_valid <= 1'b1;
            r_p_data  <= w_rdata;
            r_p_error <= w_err;
            if (q_write_i && !w_err) begin
              if (w_sel_boot) begin
                for (int i = 0; i < 4; i++) begin
                  if (q_strb_i[i]) r_entry[8*i +: 8] <= q_data_i[8*i +: 8];
                end
                if (|q_strb_i[3:0]) r_entry_valid <= 1'b1;
              end
              // The wake pulse fires on acceptance, not on the response handshake.
              if (w_sel_wake && q_strb_i[0]) begin
                r_debug_req <= w_mask;
                if (|w_mask) r_woken <= 1'b1;
              end
            end
          end
        end
        S_RESP: begin
          if (p_ready_i) begin
            r_state   <= S_IDLE;
            r_p_valid <= 1'b0;
            r_p_data  <= '0;
            r_p_error <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q_ready_o     = rst_ni && (r_state == S_IDLE);
  assign p_valid_o     = r_p_valid;
  assign p_data_o      = r_p_data;
  assign p_error_o     = r_p_error;
  assign entry_point_o = r_entry;
  assign entry_valid_o = r_entry_valid;
  assign debug_req_o   = r_debug_req;

endmodule

// File: tb/tb_spatz_boot_ctrl_resp.sv
// tb/tb_spatz_boot_ctrl_resp.sv - self-checking bench for spatz_boot_ctrl_resp
// Directed scenarios plus randomized traffic against a register-map reference model.
module tb_spatz_boot_ctrl_resp;

  localparam logic [47:0] BASE = 48'h0000_0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] q_addr = '0;
  logic        q_write = 1'b0;
  logic [63:0] q_data = '0;
  logic [7:0]  q_strb = '0;
  logic [3:0]  q_amo = '0;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [63:0] p_data;
  logic        p_error;
  logic        p_valid;
  logic        p_ready = 1'b0;
  logic [31:0] entry_point;
  logic [1:0]  debug_req;
  logic        entry_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_entry;
  logic        m_ev;
  logic        m_woken;

  always #5 clk = ~clk;

  spatz_boot_ctrl_resp #(
    .AddrWidth(48), .DataWidth(64), .NumCores(2), .BaseAddr(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .q_addr_i(q_addr), .q_write_i(q_write), .q_data_i(q_data), .q_strb_i(q_strb),
    .q_amo_i(q_amo), .q_valid_i(q_valid), .q_ready_o(q_ready),
    .p_data_o(p_data), .p_error_o(p_error), .p_valid_o(p_valid), .p_ready_i(p_ready),
    .entry_point_o(entry_point), .debug_req_o(debug_req), .entry_valid_o(entry_valid)
  );

  // Reference: only offsets 0x00, 0x08 and 0x10 exist; everything else is an error.
  function automatic void model_apply(input logic [47:0] addr, input logic wr,
      input logic [63:0] data, input logic [7:0] strb, input logic [3:0] amo,
      output logic [63:0] ed, output logic ee, output logic [1:0] edbg);
    logic [47:0] off;
    off  = addr - BASE;
    ee   = !((off == 48'd0) || (off == 48'd8) || (off == 48'd16)) || (amo != 4'd0);
    ed   = '0;
    edbg = '0;
    if (!ee) begin
      if (!wr) begin
        if (off == 48'd0)  ed = {32'h0, m_entry};
        if (off == 48'd16) ed = {62'h0, m_woken, m_ev};
      end else if (off == 48'd0) begin
        for (int i = 0; i < 4; i++) if (strb[i]) m_entry[8*i +: 8] = data[8*i +: 8];
        if (strb[3:0] != 4'h0) m_ev = 1'b1;
      end else if (off == 48'd8 && strb[0]) begin
        edbg = data[1:0];
        if (data[1:0] != 2'b00) m_woken = 1'b1;
      end
    end
  endfunction

  task automatic apply_reset();
    rst_n   = 1'b0;
    m_entry = '0;
    m_ev    = 1'b0;
    m_woken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input logic [47:0] addr, input logic wr, input logic [63:0] data,
      input logic [7:0] strb, input logic [3:0] amo,
      output logic [63:0] rd, output logic re, output logic [1:0] dbg,
      output logic [1:0] dbg_after, output logic pv, output logic pv_after);
    int n = 0;
    @(negedge clk);
    while (!q_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL q_ready_timeout: got q_ready=%0b required 1", q_ready);
    end
    q_addr = addr; q_write = wr; q_data = data; q_strb = strb; q_amo = amo;
    q_valid = 1'b1;
    p_ready = 1'b0;
    @(negedge clk);
    q_valid = 1'b0;
    rd = p_data; re = p_error; dbg = debug_req; pv = p_valid;
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    dbg_after = debug_req; pv_after = p_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (q_ready !== 1'b0) begin n_fail++; $display("FAIL reset_q_ready: got %b required 0", q_ready); end
    n_tests++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b required 0", p_valid); end
    n_tests++; if (p_data !== 64'h0 || p_error !== 1'b0) begin n_fail++; $display("FAIL reset_p_data: got %h/%b required 0/0", p_data, p_error); end
    n_tests++; if (entry_point !== 32'h0 || entry_valid !== 1'b0) begin n_fail++; $display("FAIL reset_entry: got %h/%b required 0/0", entry_point, entry_valid); end
    n_tests++; if (debug_req !== 2'b00) begin n_fail++; $display("FAIL reset_debug_req: got %b required 00", debug_req); end
    apply_reset();
    @(negedge clk);
    n_tests++; if (q_ready !== 1'b1) begin n_fail++; $display("FAIL release_q_ready: got %b required 1", q_ready); end
  endtask

  task automatic test_boot_write();
    logic [63:0] rd, ed; logic re, ee, pv, pva; logic [1:0] dbg, dba, edbg;
    model_apply(BASE, 1'b1, 64'h8000_0000, 8'hFF, 4'h0, ed, ee, edbg);
    do_txn(BASE, 1'b1, 64'h8000_0000, 8'hFF, 4'h0, rd, re, dbg, dba, pv, pva);
    n_tests++; if (pv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL boot_wr_resp: got valid=%b err=%b required 1/0", pv, re); end
    n_tests++; if (pva !== 1'b0) begin n_fail++; $display("FAIL boot_wr_idle: got valid=%b required 0", pva); end
    n_tests++; if (entry_point !== 32'h8000_0000 || entry_valid !== 1'b1) begin n_fail++; $display("FAIL boot_wr_entry: got %h/%b required 80000000/1", entry_point, entry_valid); end
    model_apply(BASE, 1'b0, 64'h0, 8'h00, 4'h0, ed, ee, edbg);
    do_txn(BASE, 1'b0, 64'h0, 8'h00, 4'h0, rd, re, dbg, dba, pv, pva);
    n_tests++; if (rd !== 64'h0000_0000_8000_0000 || re !== 1'b0) begin n_fail++; $display("FAIL boot_rd: got %h/%b required 0000000080000000/0", rd, re); end
  endtask

  task automatic test_wake();
    logic [63:0] rd, ed; logic re, ee, pv, pva; logic [1:0] dbg, dba, edbg;
    model_apply(BASE + 48'h8, 1'b1, 64'h3, 8'hFF, 4'h0, ed, ee, edbg);
    do_txn(BASE + 48'h8, 1'b1, 64'h3, 8'hFF, 4'h0, rd, re, dbg, dba, pv, pva);
    n_tests++; if (dbg !== 2'b11) begin n_fail++; $display("FAIL wake_pulse: got %b required 11", dbg); end
    n_tests++; if (dba !== 2'b00) begin n_fail++; $display("FAIL wake_pulse_width: got %b required 00", dba); end
    model_apply(BASE + 48'h10, 1'b0, 64'h0, 8'h00, 4'h0, ed, ee, edbg);
    do_txn(BASE + 48'h10, 1'b0, 64'h0, 8'h00, 4'h0, rd, re, dbg, dba, pv, pva);
    n_tests++; if (rd !== 64'h3 || re !== 1'b0) begin n_fail++; $display("FAIL status_rd: got %h/%b required 3/0", rd, re); end
  endtask

  task automatic test_strb();
    logic [63:0] rd, ed; logic re, ee, pv, pva; logic [1:0] dbg, dba, edbg;
    apply_reset();
    model_apply(BASE, 1'b1, 64'h1234_5678, 8'h01, 4'h0, ed, ee, edbg);
    do_txn(BASE, 1'b1, 64'h1234_5678, 8'h01, 4'h0, rd, re, dbg, dba, pv, pva);
    n_tests++; if (entry_point !== 32'h0000_0078 || entry_valid !== 1'b1) begin n_fail++; $display("FAIL strb_entry: got %h/%b required 00000078/1", entry_point, entry_valid); end
  endtask

  task automatic test_miss();
    logic [63:0] rd, ed; logic re, ee, pv, pva; logic [1:0] dbg, dba, edbg;
    logic [47:0] addrs [4];
    logic        wrs   [4];
    logic [3:0]  amos  [4];
    addrs = '{BASE + 48'h20, BASE + 48'h4, BASE - 48'h8, BASE};
    wrs   = '{1'b0, 1'b0, 1'b1, 1'b1};
    amos  = '{4'h0, 4'h0, 4'h0, 4'h2};
    for (int i = 0; i < 4; i++) begin
      model_apply(addrs[i], wrs[i], 64'hFFFF_FFFF, 8'hFF, amos[i], ed, ee, edbg);
      do_txn(addrs[i], wrs[i], 64'hFFFF_FFFF, 8'hFF, amos[i], rd, re, dbg, dba, pv, pva);
      n_tests++; if (re !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("FAIL miss_%0d: got err=%b data=%h required 1/0", i, re, rd); end
      n_tests++; if (entry_point !== m_entry) begin n_fail++; $display("FAIL miss_entry_%0d: got %h required %h", i, entry_point, m_entry); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ed1, ed2, held; logic ee1, ee2; logic [1:0] edbg;
    model_apply(BASE, 1'b0, 64'h0, 8'h00, 4'h0, ed1, ee1, edbg);
    model_apply(BASE + 48'h10, 1'b0, 64'h0, 8'h00, 4'h0, ed2, ee2, edbg);
    @(negedge clk);
    q_addr = BASE; q_write = 1'b0; q_amo = 4'h0; q_valid = 1'b1; p_ready = 1'b0;
    @(negedge clk);
    q_addr = BASE + 48'h10;
    held = p_data;
    n_tests++; if (held !== ed1) begin n_fail++; $display("FAIL bp_first_data: got %h required %h", held, ed1); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (p_valid !== 1'b1 || p_data !== held || q_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b required 1/%h/0", k, p_valid, p_data, q_ready, held);
      end
      if (k < 4) @(negedge clk);
    end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    n_tests++; if (p_valid !== 1'b0 || q_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b required 0/1", p_valid, q_ready); end
    @(negedge clk);
    q_valid = 1'b0;
    n_tests++; if (p_valid !== 1'b1 || p_data !== ed2 || p_error !== 1'b0) begin n_fail++; $display("FAIL bp_second: got valid=%b data=%h err=%b required 1/%h/0", p_valid, p_data, p_error, ed2); end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    q_addr = BASE; q_write = 1'b0; q_amo = 4'h0; q_valid = 1'b1; p_ready = 1'b0;
    @(negedge clk);
    q_valid = 1'b0;
    n_tests++; if (p_valid !== 1'b1) begin n_fail++; $display("FAIL rr_pending: got %b required 1", p_valid); end
    rst_n = 1'b0;
    m_entry = '0; m_ev = 1'b0; m_woken = 1'b0;
    #1;
    n_tests++; if (p_valid !== 1'b0 || entry_point !== 32'h0 || q_ready !== 1'b0) begin n_fail++; $display("FAIL rr_async: got valid=%b entry=%h ready=%b required 0/0/0", p_valid, entry_point, q_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (p_valid !== 1'b0) begin n_fail++; $display("FAIL rr_stale_%0d: got %b required 0", k, p_valid); end
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, ed, data; logic re, ee, pv, pva, wr; logic [1:0] dbg, dba, edbg;
    logic [47:0] addr; logic [7:0] strb; logic [3:0] amo; int sel;
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 7);
      if (sel < 6)       addr = BASE + 48'(8 * (sel % 3));
      else if (sel == 6) addr = BASE + 48'($urandom_range(0, 63));
      else               addr = BASE - 48'(8 * $urandom_range(1, 4));
      wr   = 1'($urandom_range(0, 1));
      data = {$urandom, $urandom};
      strb = 8'($urandom_range(0, 255));
      amo  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      model_apply(addr, wr, data, strb, amo, ed, ee, edbg);
      do_txn(addr, wr, data, strb, amo, rd, re, dbg, dba, pv, pva);
      n_tests++;
      if (pv !== 1'b1 || pva !== 1'b0 || rd !== ed || re !== ee) begin
        n_fail++; $display("FAIL rnd_resp_%0d: got v=%b/%b d=%h e=%b required 1/0 d=%h e=%b", t, pv, pva, rd, re, ed, ee);
      end
      n_tests++;
      if (dbg !== edbg || dba !== 2'b00) begin
        n_fail++; $display("FAIL rnd_wake_%0d: got %b/%b required %b/00", t, dbg, dba, edbg);
      end
      n_tests++;
      if (entry_point !== m_entry || entry_valid !== m_ev) begin
        n_fail++; $display("FAIL rnd_state_%0d: got %h/%b required %h/%b", t, entry_point, entry_valid, m_entry, m_ev);
      end
    end
  endtask

  initial begin
    m_entry = '0; m_ev = 1'b0; m_woken = 1'b0;
    test_reset();
    test_boot_write();
    test_wake();
    test_strb();
    test_miss();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
